// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared next-PC encodings and default address constants
// Purpose: NPCSel encodings and default reset/exception/fetch-window constants
//          used by the pc_gen top, its RAS, and the testbench.
// Ports: none (package).
package pc_gen_pkg;

  typedef enum logic [2:0] {
    PCPLUS4 = 3'd0,
    IMM26   = 3'd1,
    GRFDATA = 3'd2,
    IMM16   = 3'd3,
    RAS     = 3'd4
  } npc_sel_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;
  localparam logic [31:0] IM_LO_DEF    = 32'h0000_3000;
  localparam logic [31:0] IM_HI_DEF    = 32'h0000_6ffc;

endpackage

// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - D-stage/CP0 to fetch PC generator signal bundle
// Purpose: groups redirect inputs and fetch-side outputs of pc_gen.
// Ports (slave view = pc_gen):
//   in : stall, Req, eret, EPC, D_PC, NPCSel, imm26, imm16, GRF, zero,
//        ras_push, ras_pop
//   out: F_PC, F_AdEL, ras_valid, ras_top
interface pc_gen_if #(
  parameter int ADDR_W = 32
);

  logic              stall;
  logic              Req;
  logic              eret;
  logic [ADDR_W-1:0] EPC;
  logic [ADDR_W-1:0] D_PC;
  logic [2:0]        NPCSel;
  logic [25:0]       imm26;
  logic [15:0]       imm16;
  logic [ADDR_W-1:0] GRF;
  logic              zero;
  logic              ras_push;
  logic              ras_pop;
  logic [ADDR_W-1:0] F_PC;
  logic              F_AdEL;
  logic              ras_valid;
  logic [ADDR_W-1:0] ras_top;

  modport master (
    output stall, Req, eret, EPC, D_PC, NPCSel, imm26, imm16, GRF, zero,
           ras_push, ras_pop,
    input  F_PC, F_AdEL, ras_valid, ras_top
  );

  modport slave (
    input  stall, Req, eret, EPC, D_PC, NPCSel, imm26, imm16, GRF, zero,
           ras_push, ras_pop,
    output F_PC, F_AdEL, ras_valid, ras_top
  );

endinterface

// File: rtl/pc_gen_ras.sv
// rtl/pc_gen_ras.sv - circular return-address stack with saturating count
// Purpose: stores return addresses for jal/jalr, serves them to jr $ra.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   push, pop         : already qualified by the caller (stall/Req masked)
//   push_val          : return address to store
//   valid, top        : stack non-empty, entry at the top pointer
module pc_gen_ras #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_val,
  output logic              valid,
  output logic [ADDR_W-1:0] top
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] entry_q [DEPTH];
  logic [ADDR_W-1:0] entry_d [DEPTH];
  logic [PTR_W-1:0]  tp_q, tp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  tp_inc;

  assign tp_inc = tp_q + 1'b1;

  always_comb begin
    entry_d = entry_q;
    tp_d    = tp_q;
    cnt_d   = cnt_q;
    if (push && pop && cnt_q != '0) begin
      // Call and return in the same slot: swap the top in place.
      entry_d[tp_q] = push_val;
    end else if (push) begin
      // Wrapping the pointer overwrites the oldest entry when full.
      tp_d            = tp_inc;
      entry_d[tp_inc] = push_val;
      if (cnt_q != CNT_FULL) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (pop && cnt_q != '0) begin
      tp_d  = tp_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      tp_q  <= '0;
      cnt_q <= '0;
    end else begin
      entry_q <= entry_d;
      tp_q    <= tp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid = (cnt_q != '0);
  assign top   = entry_q[tp_q];

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program counter register and next-PC select
// Purpose: owns F_PC; applies reset/exception/eret/stall/NPCSel priority,
//          flags illegal fetch addresses and drives the return-address stack.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : pc_gen_if slave (redirect inputs in, F_PC/F_AdEL/RAS out)
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [ADDR_W-1:0] EXC_VEC   = EXC_VEC_DEF,
  parameter logic [ADDR_W-1:0] IM_LO     = IM_LO_DEF,
  parameter logic [ADDR_W-1:0] IM_HI     = IM_HI_DEF,
  parameter int                RAS_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  pc_gen_if.slave  bus
);

  logic [ADDR_W-1:0] f_pc_q, f_pc_d;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] j_target;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] sel_pc;
  logic              ras_en;
  logic              ras_valid;
  logic [ADDR_W-1:0] ras_top;

  assign pc_plus4  = f_pc_q + ADDR_W'(4);
  assign j_target  = {bus.D_PC[ADDR_W-1:28], bus.imm26, 2'b00};
  assign br_target = bus.D_PC + ADDR_W'(4)
                   + {{(ADDR_W-18){bus.imm16[15]}}, bus.imm16, 2'b00};

  // The stack moves only when D actually advances and is not being flushed.
  assign ras_en = !bus.stall && !bus.Req;

  always_comb begin
    sel_pc = pc_plus4;
    case (bus.NPCSel)
      PCPLUS4: sel_pc = pc_plus4;
      IMM26:   sel_pc = j_target;
      GRFDATA: sel_pc = bus.GRF;
      IMM16:   sel_pc = bus.zero ? br_target : pc_plus4;
      // Uses the top before any same-cycle pop lands.
      RAS:     sel_pc = ras_valid ? ras_top : bus.GRF;
      default: sel_pc = pc_plus4;
    endcase
  end

  always_comb begin
    f_pc_d = sel_pc;
    if (bus.Req) begin
      f_pc_d = EXC_VEC;
    end else if (bus.eret && !bus.stall) begin
      f_pc_d = bus.EPC;
    end else if (bus.stall) begin
      f_pc_d = f_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc_q <= RESET_PC;
    end else begin
      f_pc_q <= f_pc_d;
    end
  end

  pc_gen_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .reset    (reset),
    .push     (bus.ras_push && ras_en),
    .pop      (bus.ras_pop && ras_en),
    .push_val (bus.D_PC + ADDR_W'(8)),
    .valid    (ras_valid),
    .top      (ras_top)
  );

  assign bus.F_PC      = f_pc_q;
  assign bus.F_AdEL    = (f_pc_q[1:0] != 2'b00) || (f_pc_q < IM_LO) || (f_pc_q > IM_HI);
  assign bus.ras_valid = ras_valid;
  assign bus.ras_top   = ras_top;

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Fetch-stage program-counter generator. It owns the F_PC register and replaces the purely combinational next-PC selector.
- Adds a parametrised reset PC, exception vector, eret return via EPC, stall hold, fetch address-error detection, and a return-address stack (RAS) of parametrised depth for `jal`/`jr $ra` targets.
- Sits between the D-stage decoder/CP0 and the instruction memory address port.

Parameters:
- ADDR_W, 32: PC/address width.
- RESET_PC, 32'h00003000: F_PC value after reset.
- EXC_VEC, 32'h00004180: exception/interrupt handler entry.
- IM_LO, 32'h00003000: lowest legal fetch address.
- IM_HI, 32'h00006ffc: highest legal fetch address.
- RAS_DEPTH, 4: RAS entries (power of two, ≥2).

Ports:
- clk, in, 1: clock, rising-edge.
- reset, in, 1: synchronous, active-high.
- stall, in, 1: D-stage hazard stall; hold F_PC.
- Req, in, 1: exception/interrupt request from CP0.
- eret, in, 1: eret decoded in D.
- EPC, in, ADDR_W: CP0 return address.
- D_PC, in, ADDR_W: PC of the instruction in D.
- NPCSel, in, 3: 0 PC+4, 1 IMM26, 2 GRF, 3 IMM16, 4 RAS.
- imm26, in, 26: jump index.
- imm16, in, 16: branch offset.
- GRF, in, ADDR_W: forwarded register value for `jr`/`jalr`.
- zero, in, 1: branch condition true.
- ras_push, in, 1: `jal`/`jalr` in D.
- ras_pop, in, 1: `jr $ra` in D.
- F_PC, out, ADDR_W: current fetch address (registered).
- F_AdEL, out, 1: fetch address error on current F_PC.
- ras_valid, out, 1: RAS not empty.
- ras_top, out, ADDR_W: top RAS entry.

Behaviour:
- Reset (synchronous, active-high):
  - F_PC = RESET_PC; RAS count = 0 and pointer = 0; ras_valid = 0; ras_top = 0.
  - All RAS entries cleared to 0.
- F_PC updates every rising edge. Next-PC priority, highest first:
  1. reset → RESET_PC.
  2. Req → EXC_VEC, overriding stall.
  3. eret and !stall → EPC.
  4. stall → hold F_PC.
  5. NPCSel, evaluated as below.
- NPCSel targets (all arithmetic modulo 2^ADDR_W, wrap silently):
  - 0: F_PC+4.
  - 1: {D_PC[31:28], imm26, 2'b00}.
  - 2: GRF, unmodified; misalignment is reported via F_AdEL next cycle.
  - 3: if zero, D_PC + 4 + (sext(imm16) << 2); else F_PC+4.
  - 4: ras_top if ras_valid; otherwise GRF (fallback).
  - 5–7: F_PC+4.
- F_AdEL is combinational on F_PC:
  - Set when F_PC[1:0] != 0, or F_PC < IM_LO, or F_PC > IM_HI.
  - Equals 0 immediately after reset.
- RAS is circular, with top pointer tp and saturating count cnt.
  - push value = D_PC+8 (return address past the delay slot).
  - Push only: tp = tp+1 mod DEPTH; entry[tp'] = value; cnt = min(cnt+1, DEPTH). On overflow the oldest entry is overwritten.
  - Pop only, cnt>0: tp = tp−1 mod DEPTH; cnt = cnt−1.
  - Pop only, cnt==0: ignored, no state change.
  - Push and pop together: replace entry[tp] with value; tp and cnt unchanged. If cnt==0, behave as a push.
  - Push and pop are ignored when stall, Req, or reset is high.
  - RAS is not flushed on Req or eret.
- ras_valid = (cnt != 0). ras_top = entry[tp], combinational.
- The RAS mode NPCSel=4 uses the pre-update stack (value before the same-cycle pop).
- Latency: redirect inputs in cycle n appear on F_PC in cycle n+1. No internal bubbles.

Decomposition:
- Shared package (or header): NPCSel encodings (PCPLUS4, IMM26, GRFDATA, IMM16, RAS) and the default constants RESET_PC and EXC_VEC.
- One sub-module, pc_gen_ras: RAS storage, pointer, and count, with push/pop/valid/top ports. pc_gen instantiates it and holds the F_PC register and selection logic.

Test Plan:
1. Reset held 2 cycles, then released with NPCSel=0 → F_PC = 0x3000, 0x3004, 0x3008; F_AdEL = 0; ras_valid = 0.
2. D_PC=0x3010, NPCSel=3, imm16=0xfffe, zero=1 → next F_PC = 0x300c. Repeat with zero=0 and F_PC=0x3014 → next F_PC = 0x3018.
3. stall=1 with Req=1 at F_PC=0x3020 → next F_PC = 0x4180. Then stall=1, Req=0, eret=1, EPC=0x3040 → F_PC holds. Then stall=0, eret=1 → next F_PC = 0x3040.
4. With RAS_DEPTH=4, push five times with D_PC = 0x3000, 0x3100, 0x3200, 0x3300, 0x3400 → cnt = 4; pops return tops 0x3408, 0x3308, 0x3208, 0x3108; a fifth pop is ignored with ras_valid = 0.
5. NPCSel=4 with empty RAS and GRF=0x3abc → next F_PC = 0x3abc. With one entry 0x3050 and a simultaneous pop → next F_PC = 0x3050 and ras_valid drops to 0.
6. NPCSel=2 with GRF=0x3002 → F_AdEL = 1 next cycle. With GRF=0x7000 → F_AdEL = 1. With GRF=0x6ffc → F_AdEL = 0.
